// File: rtl/ahb_chk_pkg.sv
// Shared types and helpers for the AHB-Lite protocol checker.
// Holds transfer/burst encodings, rule ids and address arithmetic.
package ahb_chk_pkg;

    localparam int NUM_CHECKS = 8;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        CHK_STAB         = 3'd0,
        CHK_SEQ_NO_BURST = 3'd1,
        CHK_ADDR_SEQ     = 3'd2,
        CHK_EARLY_TERM   = 3'd3,
        CHK_SIZE         = 3'd4,
        CHK_ALIGN        = 3'd5,
        CHK_KB_CROSS     = 3'd6,
        CHK_ERR_RESP     = 3'd7
    } chk_id_e;

    typedef enum logic [1:0] {
        BT_IDLE       = 2'd0,
        BT_INCR_UNDEF = 2'd1,
        BT_FIXED      = 2'd2
    } bt_state_e;

    // Beat count of a fixed burst; 0 for undefined-length INCR.
    function automatic logic [4:0] burst_len(hburst_e hb);
        unique case (hb)
            HB_SINGLE:          return 5'd1;
            HB_WRAP4, HB_INCR4: return 5'd4;
            HB_WRAP8, HB_INCR8: return 5'd8;
            HB_WRAP16, HB_INCR16: return 5'd16;
            default:            return 5'd0;
        endcase
    endfunction

    // Odd encodings are the incrementing burst types.
    function automatic logic is_incr(hburst_e hb);
        return hb[0];
    endfunction

    function automatic logic is_wrap(hburst_e hb);
        return !hb[0] && (hb != HB_SINGLE);
    endfunction

    // Address of the beat following addr within its burst.
    function automatic logic [63:0] next_addr(
        logic [63:0] addr,
        logic [2:0]  hsize,
        hburst_e     hb
    );
        logic [63:0] inc;
        logic [63:0] mask;
        inc  = 64'd1 << hsize;
        mask = ({59'd0, burst_len(hb)} << hsize) - 64'd1;
        if (is_wrap(hb)) begin
            return (addr & ~mask) | ((addr + inc) & mask);
        end
        return addr + inc;
    endfunction

endpackage

// File: rtl/ahb_protocol_checker_if.sv
// AHB-Lite slave-port signal bundle.
// The checker only ever observes it through the monitor view.
interface ahb_protocol_checker_if
    import ahb_chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    htrans_e               htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    hburst_e               hburst;
    logic [3:0]            hprot;
    logic                  hready;
    logic                  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot,
        input  hready, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot,
        output hready, hresp
    );

    modport monitor (
        input hsel, haddr, htrans, hwrite, hsize, hburst, hprot,
        input hready, hresp
    );
endinterface

// File: rtl/ahb_burst_tracker.sv
// Follows the burst in progress: state, beats left, next address,
// 1KB page of the last beat and whether an ERROR hit this burst.
module ahb_burst_tracker
    import ahb_chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   acc,
    input  htrans_e                htrans,
    input  hburst_e                hburst,
    input  logic [2:0]             hsize,
    input  logic [ADDR_WIDTH-1:0]  haddr,
    input  logic                   hready,
    input  logic                   hresp,
    output bt_state_e              state,
    output logic [3:0]             remaining,
    output logic [ADDR_WIDTH-11:0] prev_page,
    output logic [ADDR_WIDTH-1:0]  exp_addr,
    output logic                   err_seen
);

    bt_state_e              state_n;
    logic [3:0]             rem_n;
    logic [ADDR_WIDTH-11:0] page_n;
    logic [ADDR_WIDTH-1:0]  exp_n;
    logic                   err_n;
    logic [ADDR_WIDTH-1:0]  nxt;

    assign nxt = ADDR_WIDTH'(next_addr(64'(haddr), hsize, hburst));

    // Next-state: a new NONSEQ restarts, SEQ counts down, ERROR ends.
    always_comb begin
        state_n = state;
        rem_n   = remaining;
        page_n  = prev_page;
        exp_n   = exp_addr;
        err_n   = err_seen;
        if (hresp && state != BT_IDLE) begin
            err_n = 1'b1;
        end
        if (acc && htrans == TR_NONSEQ) begin
            err_n  = 1'b0;
            page_n = haddr[ADDR_WIDTH-1:10];
            exp_n  = nxt;
            unique case (hburst)
                HB_SINGLE: state_n = BT_IDLE;
                HB_INCR:   state_n = BT_INCR_UNDEF;
                default: begin
                    state_n = BT_FIXED;
                    rem_n   = 4'(burst_len(hburst) - 5'd1);
                end
            endcase
        end else if (acc && htrans == TR_SEQ) begin
            page_n = haddr[ADDR_WIDTH-1:10];
            exp_n  = nxt;
            if (state == BT_FIXED) begin
                rem_n = remaining - 4'd1;
                if (remaining == 4'd1) begin
                    state_n = BT_IDLE;
                end
            end
        end else if (hresp && hready && state != BT_IDLE) begin
            state_n = BT_IDLE;
        end else if (htrans == TR_IDLE && hready) begin
            state_n = BT_IDLE;
        end
        if (state_n != BT_FIXED) begin
            rem_n = 4'd0;
        end
    end

    // Tracker registers; reset discards any burst in flight.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= BT_IDLE;
            remaining <= 4'd0;
            prev_page <= '0;
            exp_addr  <= '0;
            err_seen  <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= rem_n;
            prev_page <= page_n;
            exp_addr  <= exp_n;
            err_seen  <= err_n;
        end
    end

endmodule

// File: rtl/ahb_protocol_checker.sv
// Passive AHB-Lite rule checker: per-rule pulses, sticky flags,
// saturating counters and capture of the first violation.
module ahb_protocol_checker
    import ahb_chk_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [7:0]  CHK_EN     = 8'hFF
) (
    input  logic                              hclk,
    input  logic                              hresetn,
    ahb_protocol_checker_if.monitor           bus,
    input  logic                              clr,
    output logic [NUM_CHECKS-1:0]             viol_pulse,
    output logic [NUM_CHECKS-1:0]             viol_sticky,
    output logic [NUM_CHECKS*CNT_WIDTH-1:0]   viol_cnt,
    output logic                              first_valid,
    output logic [2:0]                        first_id,
    output logic [ADDR_WIDTH-1:0]             first_addr,
    output logic                              burst_active
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    logic                   acc;
    logic                   pend;
    logic [6:0]             align_mask;
    logic [NUM_CHECKS-1:0]  raw;
    logic [NUM_CHECKS-1:0]  viol;
    logic [2:0]             id_n;

    bt_state_e              state;
    logic [3:0]             remaining;
    logic [ADDR_WIDTH-11:0] prev_page;
    logic [ADDR_WIDTH-1:0]  exp_addr;
    logic                   err_seen;

    logic                   p_hsel;
    logic [ADDR_WIDTH-1:0]  p_haddr;
    htrans_e                p_htrans;
    logic                   p_hwrite;
    logic [2:0]             p_hsize;
    hburst_e                p_hburst;
    logic [3:0]             p_hprot;
    logic                   p_hready;
    logic                   p_hresp;

    logic [CNT_WIDTH-1:0]   cnt [NUM_CHECKS];

    ahb_burst_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_trk (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .acc       (acc),
        .htrans    (bus.htrans),
        .hburst    (bus.hburst),
        .hsize     (bus.hsize),
        .haddr     (bus.haddr),
        .hready    (bus.hready),
        .hresp     (bus.hresp),
        .state     (state),
        .remaining (remaining),
        .prev_page (prev_page),
        .exp_addr  (exp_addr),
        .err_seen  (err_seen)
    );

    assign burst_active = (state != BT_IDLE);

    // Rule evaluation on the values sampled at this edge.
    always_comb begin
        acc = bus.hsel && bus.hready
            && (bus.htrans inside {TR_NONSEQ, TR_SEQ});
        pend = p_hsel && !p_hready
            && (p_htrans inside {TR_NONSEQ, TR_SEQ});
        align_mask = 7'((8'd1 << bus.hsize) - 8'd1);
        raw = '0;
        raw[CHK_STAB] = pend && (
            (bus.haddr != p_haddr) || (bus.hwrite != p_hwrite)
            || (bus.hsize != p_hsize) || (bus.hburst != p_hburst)
            || (bus.hprot != p_hprot)
            || ((bus.htrans != p_htrans)
                && !(bus.htrans == TR_IDLE && p_hresp)));
        raw[CHK_SEQ_NO_BURST] = (state == BT_IDLE) && (
            (acc && bus.htrans == TR_SEQ)
            || (bus.hsel && bus.hready && bus.htrans == TR_BUSY));
        raw[CHK_ADDR_SEQ] = acc && bus.htrans == TR_SEQ
            && (bus.haddr != exp_addr);
        raw[CHK_EARLY_TERM] = (state == BT_FIXED)
            && (remaining != 4'd0)
            && !(err_seen || bus.hresp)
            && ((acc && bus.htrans == TR_NONSEQ)
                || (bus.htrans == TR_IDLE && bus.hready));
        raw[CHK_SIZE] = acc && (bus.hsize > MAX_SIZE);
        raw[CHK_ALIGN] = acc && ((bus.haddr[6:0] & align_mask) != 7'd0);
        raw[CHK_KB_CROSS] = acc && bus.htrans == TR_SEQ
            && is_incr(bus.hburst)
            && (bus.haddr[ADDR_WIDTH-1:10] != prev_page);
        raw[CHK_ERR_RESP] =
            (p_hresp && !p_hready && !(bus.hresp && bus.hready))
            || (bus.hresp && bus.hready && !(p_hresp && !p_hready));
        viol = raw & CHK_EN;
    end

    // Lowest-numbered rule wins when several fire together.
    always_comb begin
        id_n = 3'd0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (viol[i]) begin
                id_n = 3'(i);
            end
        end
    end

    // Previous-edge copy of the bus for the stability and error rules.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            p_hsel   <= 1'b0;
            p_haddr  <= '0;
            p_htrans <= TR_IDLE;
            p_hwrite <= 1'b0;
            p_hsize  <= 3'd0;
            p_hburst <= HB_SINGLE;
            p_hprot  <= 4'd0;
            p_hready <= 1'b0;
            p_hresp  <= 1'b0;
        end else begin
            p_hsel   <= bus.hsel;
            p_haddr  <= bus.haddr;
            p_htrans <= bus.htrans;
            p_hwrite <= bus.hwrite;
            p_hsize  <= bus.hsize;
            p_hburst <= bus.hburst;
            p_hprot  <= bus.hprot;
            p_hready <= bus.hready;
            p_hresp  <= bus.hresp;
        end
    end

    // Reporting state; clr wins over updates but not over the pulse.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            viol_pulse  <= '0;
            viol_sticky <= '0;
            first_valid <= 1'b0;
            first_id    <= 3'd0;
            first_addr  <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            viol_pulse <= viol;
            if (clr) begin
                viol_sticky <= '0;
                first_valid <= 1'b0;
                first_id    <= 3'd0;
                first_addr  <= '0;
                for (int i = 0; i < NUM_CHECKS; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                viol_sticky <= viol_sticky | viol;
                if (!first_valid && (viol != '0)) begin
                    first_valid <= 1'b1;
                    first_id    <= id_n;
                    first_addr  <= bus.haddr;
                end
                for (int i = 0; i < NUM_CHECKS; i++) begin
                    if (viol[i] && (cnt[i] != '1)) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHECKS; g++) begin : g_cnt
        assign viol_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end

endmodule

// File: tb/tb_ahb_protocol_checker.sv
// Directed bench for ahb_protocol_checker.
// Expected values are worked out by hand per scenario.
module tb_ahb_protocol_checker;
    import ahb_chk_pkg::*;

    localparam int AW = 32;
    localparam int CW = 4;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    viol_pulse;
    logic [7:0]    viol_sticky;
    logic [8*CW-1:0] viol_cnt;
    logic          first_valid;
    logic [2:0]    first_id;
    logic [AW-1:0] first_addr;
    logic          burst_active;

    int checks = 0;
    int errors = 0;

    ahb_protocol_checker_if #(.ADDR_WIDTH(AW)) bus ();

    ahb_protocol_checker #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (32),
        .CNT_WIDTH  (CW),
        .CHK_EN     (8'hFF)
    ) dut (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .bus          (bus),
        .clr          (clr),
        .viol_pulse   (viol_pulse),
        .viol_sticky  (viol_sticky),
        .viol_cnt     (viol_cnt),
        .first_valid  (first_valid),
        .first_id     (first_id),
        .first_addr   (first_addr),
        .burst_active (burst_active)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(htrans_e t, logic [AW-1:0] a,
                         hburst_e b, logic [2:0] s);
        bus.htrans = t;
        bus.haddr  = a;
        bus.hburst = b;
        bus.hsize  = s;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cnt_of(int i);
        return 64'(viol_cnt[i*CW +: CW]);
    endfunction

    task automatic do_clr();
        drive(TR_IDLE, 32'h0, HB_SINGLE, 3'd2);
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        bus.hsel   = 1'b1;
        bus.hwrite = 1'b0;
        bus.hprot  = 4'h3;
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        drive(TR_IDLE, 32'h0, HB_SINGLE, 3'd2);

        // reset
        step();
        step();
        chk("rst_pulse", 64'(viol_pulse), 64'h0);
        chk("rst_sticky", 64'(viol_sticky), 64'h0);
        chk("rst_cnt", 64'(viol_cnt), 64'h0);
        chk("rst_fvalid", 64'(first_valid), 64'h0);
        chk("rst_active", 64'(burst_active), 64'h0);
        hresetn = 1'b1;
        step();

        // INCR4 words at 0x100
        drive(TR_NONSEQ, 32'h100, HB_INCR4, 3'd2);
        step();
        chk("incr4_b1_pulse", 64'(viol_pulse), 64'h0);
        chk("incr4_b1_act", 64'(burst_active), 64'h1);
        drive(TR_SEQ, 32'h104, HB_INCR4, 3'd2);
        step();
        chk("incr4_b2_act", 64'(burst_active), 64'h1);
        drive(TR_SEQ, 32'h108, HB_INCR4, 3'd2);
        step();
        chk("incr4_b3_act", 64'(burst_active), 64'h1);
        drive(TR_SEQ, 32'h10C, HB_INCR4, 3'd2);
        step();
        chk("incr4_b4_act", 64'(burst_active), 64'h0);
        drive(TR_IDLE, 32'h0, HB_SINGLE, 3'd2);
        step();
        chk("incr4_sticky", 64'(viol_sticky), 64'h0);

        // WRAP4 clean, then bad third beat
        drive(TR_NONSEQ, 32'h38, HB_WRAP4, 3'd2);
        step();
        drive(TR_SEQ, 32'h3C, HB_WRAP4, 3'd2);
        step();
        drive(TR_SEQ, 32'h30, HB_WRAP4, 3'd2);
        step();
        chk("wrap4_wrap_pulse", 64'(viol_pulse), 64'h0);
        drive(TR_SEQ, 32'h34, HB_WRAP4, 3'd2);
        step();
        chk("wrap4_act", 64'(burst_active), 64'h0);
        drive(TR_IDLE, 32'h0, HB_SINGLE, 3'd2);
        step();
        chk("wrap4_sticky", 64'(viol_sticky), 64'h0);
        drive(TR_NONSEQ, 32'h38, HB_WRAP4, 3'd2);
        step();
        drive(TR_SEQ, 32'h3C, HB_WRAP4, 3'd2);
        step();
        drive(TR_SEQ, 32'h40, HB_WRAP4, 3'd2);
        step();
        chk("wrap4_bad_pulse", 64'(viol_pulse), 64'h04);
        chk("wrap4_bad_cnt2", cnt_of(2), 64'h1);
        drive(TR_SEQ, 32'h44, HB_WRAP4, 3'd2);
        step();
        chk("wrap4_last_pulse", 64'(viol_pulse), 64'h0);
        chk("wrap4_fid", 64'(first_id), 64'h2);
        chk("wrap4_faddr", 64'(first_addr), 64'h40);
        drive(TR_IDLE, 32'h0, HB_SINGLE, 3'd2);
        step();
        do_clr();
        chk("clr1_sticky", 64'(viol_sticky), 64'h0);
        chk("clr1_fvalid", 64'(first_valid), 64'h0);

        // address change while stalled
        drive(TR_NONSEQ, 32'h200, HB_SINGLE, 3'd2);
        bus.hready = 1'b0;
        step();
        chk("stab_wait_pulse", 64'(viol_pulse), 64'h0);
        bus.haddr = 32'h204;
        step();
        chk("stab_pulse", 64'(viol_pulse), 64'h01);
        chk("stab_fid", 64'(first_id), 64'h0);
        chk("stab_faddr", 64'(first_addr), 64'h204);
        bus.hready = 1'b1;
        step();
        chk("stab_done_pulse", 64'(viol_pulse), 64'h0);
        do_clr();

        // INCR8 cut short by NONSEQ
        drive(TR_NONSEQ, 32'h300, HB_INCR8, 3'd2);
        step();
        drive(TR_SEQ, 32'h304, HB_INCR8, 3'd2);
        step();
        drive(TR_SEQ, 32'h308, HB_INCR8, 3'd2);
        step();
        drive(TR_NONSEQ, 32'h400, HB_SINGLE, 3'd2);
        step();
        chk("early_pulse", 64'(viol_pulse), 64'h08);
        chk("early_act", 64'(burst_active), 64'h0);
        do_clr();

        // same burst ended by a two-cycle ERROR
        drive(TR_NONSEQ, 32'h300, HB_INCR8, 3'd2);
        step();
        drive(TR_SEQ, 32'h304, HB_INCR8, 3'd2);
        bus.hready = 1'b0;
        bus.hresp  = 1'b1;
        step();
        chk("err1_pulse", 64'(viol_pulse), 64'h0);
        bus.htrans = TR_IDLE;
        bus.hready = 1'b1;
        step();
        chk("err2_pulse", 64'(viol_pulse), 64'h0);
        chk("err2_act", 64'(burst_active), 64'h0);
        bus.hresp = 1'b0;
        drive(TR_NONSEQ, 32'h400, HB_SINGLE, 3'd2);
        step();
        chk("err_nonseq_pulse", 64'(viol_pulse), 64'h0);
        chk("err_sticky", 64'(viol_sticky), 64'h0);
        do_clr();

        // oversize, then misaligned
        drive(TR_NONSEQ, 32'h8, HB_SINGLE, 3'd3);
        step();
        chk("size_pulse", 64'(viol_pulse), 64'h10);
        drive(TR_NONSEQ, 32'h2, HB_SINGLE, 3'd2);
        step();
        chk("align_pulse", 64'(viol_pulse), 64'h20);
        chk("sz_sticky", 64'(viol_sticky), 64'h30);
        chk("sz_fid", 64'(first_id), 64'h4);
        chk("sz_faddr", 64'(first_addr), 64'h8);
        chk("sz_cnt5", cnt_of(5), 64'h1);

        // unsolicited single-cycle ERROR
        drive(TR_IDLE, 32'h0, HB_SINGLE, 3'd2);
        bus.hresp = 1'b1;
        step();
        chk("resp_pulse", 64'(viol_pulse), 64'h80);
        bus.hresp = 1'b0;
        step();
        chk("resp_after_pulse", 64'(viol_pulse), 64'h0);
        chk("resp_sticky", 64'(viol_sticky), 64'hB0);
        do_clr();

        // SEQ outside a burst until the counter saturates
        drive(TR_SEQ, 32'h500, HB_SINGLE, 3'd2);
        for (int i = 1; i <= (1 << CW) + 3; i++) begin
            step();
            if (i == 14) begin
                chk("sat_cnt14", cnt_of(1), 64'd14);
            end
        end
        chk("sat_cnt_max", cnt_of(1), 64'hF);
        chk("sat_pulse1", 64'(viol_pulse[1]), 64'h1);

        // clr beats a same-edge violation; the pulse still shows
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_pulse1", 64'(viol_pulse[1]), 64'h1);
        chk("clr_cnt", 64'(viol_cnt), 64'h0);
        chk("clr_sticky", 64'(viol_sticky), 64'h0);
        chk("clr_fvalid", 64'(first_valid), 64'h0);
        drive(TR_IDLE, 32'h0, HB_SINGLE, 3'd2);
        step();
        chk("post_pulse", 64'(viol_pulse), 64'h0);
        chk("post_sticky", 64'(viol_sticky), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_protocol_checker.md
Name: ahb_protocol_checker

Overview:
Synthesizable, passive AHB-Lite protocol checker. It observes the master/slave signals at a slave port and flags rule violations as registered per-rule pulses, sticky flags and saturating counters. It is the parametrised, reusable successor to the bench-side assertions: configurable bus widths and per-rule enables, and it adds burst-beat tracking, expected-address checks and first-violation capture. It sits beside any AHB-Lite slave, in the bench top or in silicon debug logic.

Parameters:
ADDR_WIDTH, 32, haddr width (>=11)
DATA_WIDTH, 32, data bus width in bits (8..1024, power of 2); sets max legal hsize
CNT_WIDTH, 16, width of each per-rule violation counter
CHK_EN, 8'hFF, per-rule enable mask; bit i enables rule i

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  ADDR_WIDTH  address
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  direction
hsize  in  3  transfer size
hburst  in  3  SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
hprot  in  4  protection
hready  in  1  bus ready (slave HREADYOUT)
hresp  in  1  0=OKAY, 1=ERROR
clr  in  1  synchronous clear of sticky flags, counters and capture
viol_pulse  out  8  one-cycle pulse per rule
viol_sticky  out  8  sticky per-rule flags
viol_cnt  out  8*CNT_WIDTH  packed saturating counters, rule i at [i*CNT_WIDTH +: CNT_WIDTH]
first_valid  out  1  first-violation capture holds data
first_id  out  3  rule id of first violation (lowest id wins on ties)
first_addr  out  ADDR_WIDTH  haddr sampled at the first violation
burst_active  out  1  burst tracker is inside a burst

Behaviour:
- All outputs reset to 0. Tracker resets to IDLE with beat count 0; reset mid-burst discards the burst.
- "Accepted" means that at a posedge, hsel && hready && htrans is NONSEQ or SEQ. All rules are evaluated on sampled values at posedge. The result is registered, so viol_pulse rises 1 cycle after the offending edge. Counters and sticky flags update on that same edge.
- Rule 0 STAB: the previous edge had hsel, htrans in {NONSEQ, SEQ} and !hready, and the current haddr, hwrite, hsize, hburst or hprot differs, or htrans changes. Exception: htrans changing to IDLE is legal when the previous edge had hresp=1.
- Rule 1 SEQ_NO_BURST: SEQ accepted, or BUSY sampled with hsel && hready, while the tracker is IDLE.
- Rule 2 ADDR_SEQ: SEQ accepted and haddr differs from the expected address.
  - INCR types: expected = prev_addr + (1<<hsize).
  - WRAPn: expected = (prev_addr & ~(B-1)) | ((prev_addr + (1<<hsize)) & (B-1)), where B = n<<hsize.
- Rule 3 EARLY_TERM: a fixed-length burst has remaining beats > 0, and NONSEQ is accepted or IDLE is sampled with hready. Suppressed if any ERROR response occurred during the burst.
- Rule 4 SIZE: accepted transfer with hsize > log2(DATA_WIDTH/8).
- Rule 5 ALIGN: accepted transfer with haddr mod (1<<hsize) != 0.
- Rule 6 KB_CROSS: SEQ accepted in an INCR-type burst and haddr[ADDR_WIDTH-1:10] differs from the previous beat's.
- Rule 7 ERR_RESP:
  - The previous edge had hresp=1 && !hready, and the current edge is not hresp=1 && hready.
  - Or hresp=1 && hready with no preceding hresp=1 && !hready.
- Burst tracker states: IDLE, INCR_UNDEF, FIXED.
  - On NONSEQ accepted: SINGLE -> IDLE; INCR -> INCR_UNDEF; others -> FIXED with remaining = len-1.
  - On SEQ accepted in FIXED: remaining decrements; at 0 the tracker goes to IDLE.
  - BUSY is not a beat and changes no state.
  - IDLE sampled with hready -> IDLE.
  - Error mid-burst terminates the burst: IDLE on the second ERROR cycle.
  - burst_active = state != IDLE.
- Disabled rules (CHK_EN bit 0) never pulse.
- Counters saturate at all-ones. Sticky flags are set by the pulse.
- First capture loads only while first_valid=0.
- clr has priority over same-edge updates of sticky flags, counters and capture. viol_pulse is still emitted.

Decomposition:
- Package ahb_chk_pkg holds:
  - enums htrans_e, hburst_e and chk_id_e (8 ids)
  - localparam NUM_CHECKS=8
  - functions burst_len(hburst) and next_addr(addr, hsize, hburst)
- Sub-module ahb_burst_tracker holds the state machine, remaining-beat counter, previous address, expected address and the error-seen flag.
- The top module holds the rules, counters and capture logic.

Test Plan:
- INCR4 of words at 0x100, 0x104, 0x108, 0x10C -> no pulses; burst_active high for 3 cycles after the NONSEQ edge, then low.
- WRAP4 word burst starting at 0x38 with beats 0x38, 0x3C, 0x30, 0x34 -> clean. Changing beat 3 to 0x40 -> viol_pulse[2] and viol_cnt[2]=1.
- NONSEQ at 0x200 with hready held low 2 cycles while haddr changes to 0x204 -> viol_pulse[0], first_id=0, first_addr=0x204.
- INCR8 terminated by NONSEQ after 3 beats -> viol_pulse[3]. Repeating it with a 2-cycle ERROR at beat 2 -> no pulse[3] and no pulse[7].
- DATA_WIDTH=32 with hsize=3 at 0x8, then hsize=2 at 0x2 -> pulses [4] then [5]. Sticky 8'h30; first_id=4.
- 2^CNT_WIDTH+3 SEQ-without-burst errors -> viol_cnt[1] = all-ones. A clr pulse -> counters, sticky and first_valid are 0.
